// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the single-bus CPU.
// It fetches an instruction, latches its opcode, and walks through that
// instruction's micro-operation states. The control word is held in flops
// that are loaded with the decode of the state being entered, so every
// output comes straight from a register and clears asynchronously with the state.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        IR_enable,
  output logic        PC_enable,
  output logic        Y_enable,
  output logic        Z_low_enable,
  output logic        Z_high_enable,
  output logic        CON_enable,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  operation
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH0 = 4'd1,
    S_FETCH1 = 4'd2,
    S_FETCH2 = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  // Instruction families that share a micro-operation sequence.
  typedef enum logic [2:0] {
    C_LD   = 3'd0,
    C_LDI  = 3'd1,
    C_ST   = 3'd2,
    C_ALU  = 3'd3,
    C_IMM  = 3'd4,
    C_BR   = 3'd5,
    C_NOP  = 3'd6,
    C_HALT = 3'd7
  } class_t;

  typedef struct packed {
    logic       run;
    logic       pc_out;
    logic       zlow_out;
    logic       zhigh_out;
    logic       mdr_out;
    logic       hi_out;
    logic       lo_out;
    logic       inport_out;
    logic       c_out;
    logic       mar_en;
    logic       mdr_en;
    logic       ir_en;
    logic       pc_en;
    logic       y_en;
    logic       zlow_en;
    logic       zhigh_en;
    logic       con_en;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       ba_out;
    logic [4:0] operation;
  } ctrl_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  // Map an opcode to its sequence family; nop and undefined codes share C_NOP.
  function automatic class_t classify(input logic [4:0] op);
    class_t cls;
    case (op)
      OP_LD:                          cls = C_LD;
      OP_LDI:                         cls = C_LDI;
      OP_ST:                          cls = C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  cls = C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:       cls = C_IMM;
      OP_BR:                          cls = C_BR;
      OP_HALT:                        cls = C_HALT;
      default:                        cls = C_NOP;
    endcase
    return cls;
  endfunction

  // ALU function used by the immediate forms.
  function automatic logic [4:0] imm_alu(input logic [4:0] op);
    logic [4:0] alu;
    case (op)
      OP_ANDI: alu = ALU_AND;
      OP_ORI:  alu = ALU_OR;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

  // Control word for a given state; con only matters in br T6.
  function automatic ctrl_t decode(input state_t st, input logic [4:0] op, input logic con);
    ctrl_t  c;
    class_t cls;
    c     = '0;
    cls   = classify(op);
    c.run = (st != S_RESET) && (st != S_HALT);
    case (st)
      S_FETCH0: begin c.pc_out = 1'b1; c.mar_en = 1'b1; c.inc_pc = 1'b1; end
      S_FETCH1: begin c.read = 1'b1; c.mdr_en = 1'b1; end
      S_FETCH2: begin c.mdr_out = 1'b1; c.ir_en = 1'b1; end
      S_T3: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_en = 1'b1; end
          C_ALU, C_IMM:      begin c.grb = 1'b1; c.rout = 1'b1; c.y_en = 1'b1; end
          C_BR:              begin c.gra = 1'b1; c.rout = 1'b1; c.con_en = 1'b1; end
          default:           begin end
        endcase
      end
      S_T4: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin c.c_out = 1'b1; c.operation = ALU_ADD; c.zlow_en = 1'b1; end
          C_ALU:             begin c.grc = 1'b1; c.rout = 1'b1; c.operation = op; c.zlow_en = 1'b1; end
          C_IMM:             begin c.c_out = 1'b1; c.operation = imm_alu(op); c.zlow_en = 1'b1; end
          C_BR:              begin c.pc_out = 1'b1; c.y_en = 1'b1; end
          default:           begin end
        endcase
      end
      S_T5: begin
        case (cls)
          C_LD, C_ST:          begin c.zlow_out = 1'b1; c.mar_en = 1'b1; end
          C_LDI, C_ALU, C_IMM: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          C_BR:                begin c.c_out = 1'b1; c.operation = ALU_ADD; c.zlow_en = 1'b1; end
          default:             begin end
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD: begin c.read = 1'b1; c.mdr_en = 1'b1; end
          C_ST: begin c.gra = 1'b1; c.rout = 1'b1; c.mdr_en = 1'b1; end
          C_BR: begin
            if (con) begin
              c.zlow_out = 1'b1;
              c.pc_en    = 1'b1;
            end else begin
              c.zlow_out = 1'b0;
              c.pc_en    = 1'b0;
            end
          end
          default: begin end
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD:    begin c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          C_ST:    begin c.write = 1'b1; end
          default: begin end
        endcase
      end
      default: begin end
    endcase
    return c;
  endfunction

  state_t     state_r, state_next_s, done_next_s;
  logic [4:0] opcode_r, opcode_next_s;
  logic       release_r;
  ctrl_t      ctrl_r;
  class_t     cls_s;

  // Opcode copy: captured from IR only as FETCH2 ends, held otherwise.
  always_comb begin
    opcode_next_s = opcode_r;
    if (state_r == S_FETCH2) begin
      opcode_next_s = IR[31:27];
    end else begin
      opcode_next_s = opcode_r;
    end
  end

  // Next-state logic; an instruction's final state goes to FETCH0 unless stop is high.
  always_comb begin
    state_next_s = state_r;
    cls_s        = classify(opcode_r);
    if (stop) begin
      done_next_s = S_HALT;
    end else begin
      done_next_s = S_FETCH0;
    end
    case (state_r)
      S_RESET: begin
        if (release_r) begin
          state_next_s = S_FETCH0;
        end else begin
          state_next_s = S_RESET;
        end
      end
      S_FETCH0: state_next_s = S_FETCH1;
      S_FETCH1: state_next_s = S_FETCH2;
      S_FETCH2: state_next_s = S_T3;
      S_T3: begin
        if (cls_s == C_HALT) begin
          state_next_s = S_HALT;
        end else if (cls_s == C_NOP) begin
          state_next_s = done_next_s;
        end else begin
          state_next_s = S_T4;
        end
      end
      S_T4: state_next_s = S_T5;
      S_T5: begin
        if ((cls_s == C_LD) || (cls_s == C_ST) || (cls_s == C_BR)) begin
          state_next_s = S_T6;
        end else begin
          state_next_s = done_next_s;
        end
      end
      S_T6: begin
        if (cls_s == C_BR) begin
          state_next_s = done_next_s;
        end else begin
          state_next_s = S_T7;
        end
      end
      S_T7:    state_next_s = done_next_s;
      S_HALT:  state_next_s = S_HALT;
      default: state_next_s = S_RESET;
    endcase
  end

  // Hold RESET for one edge after clear rises so FETCH0 lands on the second edge.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      release_r <= 1'b0;
    end else begin
      release_r <= 1'b1;
    end
  end

  // State and latched opcode registers.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r  <= S_RESET;
      opcode_r <= 5'b00000;
    end else begin
      state_r  <= state_next_s;
      opcode_r <= opcode_next_s;
    end
  end

  // Output register loaded with the decode of the state being entered;
  // CON is captured on the edge that enters br T6.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ctrl_r <= '0;
    end else begin
      ctrl_r <= decode(state_next_s, opcode_next_s, CON);
    end
  end

  assign run           = ctrl_r.run;
  assign PCout         = ctrl_r.pc_out;
  assign ZLowout       = ctrl_r.zlow_out;
  assign ZHighout      = ctrl_r.zhigh_out;
  assign MDRout        = ctrl_r.mdr_out;
  assign HIout         = ctrl_r.hi_out;
  assign LOout         = ctrl_r.lo_out;
  assign InPortout     = ctrl_r.inport_out;
  assign Cout          = ctrl_r.c_out;
  assign MAR_enable    = ctrl_r.mar_en;
  assign MDR_enable    = ctrl_r.mdr_en;
  assign IR_enable     = ctrl_r.ir_en;
  assign PC_enable     = ctrl_r.pc_en;
  assign Y_enable      = ctrl_r.y_en;
  assign Z_low_enable  = ctrl_r.zlow_en;
  assign Z_high_enable = ctrl_r.zhigh_en;
  assign CON_enable    = ctrl_r.con_en;
  assign IncPC         = ctrl_r.inc_pc;
  assign Read          = ctrl_r.read;
  assign Write         = ctrl_r.write;
  assign GRA           = ctrl_r.gra;
  assign GRB           = ctrl_r.grb;
  assign GRC           = ctrl_r.grc;
  assign Rin           = ctrl_r.rin;
  assign Rout          = ctrl_r.rout;
  assign BAout         = ctrl_r.ba_out;
  assign operation     = ctrl_r.operation;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each instruction is stepped one
// state per clock and the whole control word is compared against a
// hand-written table of expected values.
module tb_control_sequencer;
  logic        clock, clear, CON, stop;
  logic [31:0] IR;
  logic run, PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout;
  logic MAR_enable, MDR_enable, IR_enable, PC_enable, Y_enable, Z_low_enable, Z_high_enable, CON_enable;
  logic IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout;
  logic [4:0] operation;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [30:0] RUN  = 31'd1 << 30;
  localparam logic [30:0] PCO  = 31'd1 << 29;
  localparam logic [30:0] ZLO  = 31'd1 << 28;
  localparam logic [30:0] MDRO = 31'd1 << 26;
  localparam logic [30:0] CO   = 31'd1 << 22;
  localparam logic [30:0] MARE = 31'd1 << 21;
  localparam logic [30:0] MDRE = 31'd1 << 20;
  localparam logic [30:0] IRE  = 31'd1 << 19;
  localparam logic [30:0] PCE  = 31'd1 << 18;
  localparam logic [30:0] YE   = 31'd1 << 17;
  localparam logic [30:0] ZLE  = 31'd1 << 16;
  localparam logic [30:0] CONE = 31'd1 << 14;
  localparam logic [30:0] INC  = 31'd1 << 13;
  localparam logic [30:0] RD   = 31'd1 << 12;
  localparam logic [30:0] WR   = 31'd1 << 11;
  localparam logic [30:0] GA   = 31'd1 << 10;
  localparam logic [30:0] GB   = 31'd1 << 9;
  localparam logic [30:0] GC   = 31'd1 << 8;
  localparam logic [30:0] RIN  = 31'd1 << 7;
  localparam logic [30:0] ROUT = 31'd1 << 6;
  localparam logic [30:0] BAO  = 31'd1 << 5;
  localparam logic [30:0] ADD  = 31'd3;
  localparam logic [30:0] OR_  = 31'd6;

  logic [30:0] obs;
  logic [30:0] exp_tab [0:7];

  assign obs = {run, PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout,
                MAR_enable, MDR_enable, IR_enable, PC_enable, Y_enable, Z_low_enable,
                Z_high_enable, CON_enable, IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout,
                BAout, operation};

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON), .stop(stop),
    .run(run), .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .IR_enable(IR_enable),
    .PC_enable(PC_enable), .Y_enable(Y_enable), .Z_low_enable(Z_low_enable),
    .Z_high_enable(Z_high_enable), .CON_enable(CON_enable), .IncPC(IncPC),
    .Read(Read), .Write(Write), .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .operation(operation)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value with its expected value and report a mismatch.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Fetch states are common to every instruction.
  task automatic load_fetch();
    exp_tab[0] = RUN | PCO | MARE | INC;
    exp_tab[1] = RUN | RD | MDRE;
    exp_tab[2] = RUN | MDRO | IRE;
    for (int i = 3; i < 8; i++) exp_tab[i] = 31'd0;
  endtask

  // Step n states of one instruction; IR is overwritten with halt after T3
  // to show that execution uses the latched opcode.
  task automatic run_instr(input string tag, input logic [31:0] ir, input logic con,
                           input logic stop_v, input int n);
    IR  = ir;
    CON = con;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_eq($sformatf("%s_s%0d", tag, i), {1'b0, obs}, {1'b0, exp_tab[i]});
      if (i == 0 && stop_v) stop = 1'b1;
      if (i == 3) IR = 32'hD000_0000;
    end
  endtask

  // Pulse clear between clocks and check the RESET cycle after release.
  task automatic do_reset(input string tag);
    @(negedge clock);
    clear = 1'b0;
    #1 check_eq({tag, "_async"}, {1'b0, obs}, 32'd0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check_eq({tag, "_reset_state"}, {1'b0, obs}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    clear = 1'b0; IR = 32'd0; CON = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("reset_hold", {1'b0, obs}, 32'd0);
    clear = 1'b1;
    @(negedge clock);
    check_eq("reset_state", {1'b0, obs}, 32'd0);

    load_fetch();
    exp_tab[3] = RUN | GB | ROUT | YE;
    exp_tab[4] = RUN | GC | ROUT | ZLE | ADD;
    exp_tab[5] = RUN | ZLO | GA | RIN;
    run_instr("add", 32'h1800_0000, 1'b0, 1'b0, 6);

    load_fetch();
    exp_tab[3] = RUN | GB | BAO | YE;
    exp_tab[4] = RUN | CO | ZLE | ADD;
    exp_tab[5] = RUN | ZLO | MARE;
    exp_tab[6] = RUN | RD | MDRE;
    exp_tab[7] = RUN | MDRO | GA | RIN;
    run_instr("ld", 32'h0000_0000, 1'b1, 1'b0, 8);

    exp_tab[6] = RUN | GA | ROUT | MDRE;
    exp_tab[7] = RUN | WR;
    run_instr("st", 32'h1000_0000, 1'b1, 1'b0, 8);

    load_fetch();
    exp_tab[3] = RUN | GA | ROUT | CONE;
    exp_tab[4] = RUN | PCO | YE;
    exp_tab[5] = RUN | CO | ZLE | ADD;
    exp_tab[6] = RUN | ZLO | PCE;
    run_instr("br_taken", 32'h9000_0000, 1'b1, 1'b0, 7);
    exp_tab[6] = RUN;
    run_instr("br_not", 32'h9000_0000, 1'b0, 1'b0, 7);

    load_fetch();
    exp_tab[3] = RUN | GB | ROUT | YE;
    exp_tab[4] = RUN | CO | ZLE | OR_;
    exp_tab[5] = RUN | ZLO | GA | RIN;
    run_instr("ori", 32'h7000_0000, 1'b0, 1'b0, 6);

    load_fetch();
    exp_tab[3] = RUN;
    run_instr("undef", 32'hB800_0000, 1'b1, 1'b0, 4);
    run_instr("nop", 32'hC800_0000, 1'b0, 1'b0, 4);
    run_instr("halt", 32'hD000_0000, 1'b0, 1'b0, 4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_eq($sformatf("halt_idle_%0d", i), {1'b0, obs}, 32'd0);
    end

    do_reset("rst2");
    load_fetch();
    exp_tab[3] = RUN | GB | BAO | YE;
    exp_tab[4] = RUN | CO | ZLE | ADD;
    exp_tab[5] = RUN | ZLO | GA | RIN;
    run_instr("ldi_stop", 32'h0800_0000, 1'b0, 1'b1, 6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq($sformatf("stop_halt_%0d", i), {1'b0, obs}, 32'd0);
    end
    stop = 1'b0;

    do_reset("rst3");
    load_fetch();
    exp_tab[3] = RUN | GB | BAO | YE;
    exp_tab[4] = RUN | CO | ZLE | ADD;
    exp_tab[5] = RUN | ZLO | MARE;
    exp_tab[6] = RUN | RD | MDRE;
    run_instr("ld_part", 32'h0000_0000, 1'b0, 1'b0, 7);
    #2 clear = 1'b0;
    #1 check_eq("mid_reset_read", {31'd0, Read}, 32'd0);
    check_eq("mid_reset_all", {1'b0, obs}, 32'd0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check_eq("rst4_reset_state", {1'b0, obs}, 32'd0);

    load_fetch();
    exp_tab[3] = RUN;
    run_instr("undef2", 32'hB800_0000, 1'b0, 1'b0, 4);
    load_fetch();
    exp_tab[3] = RUN | GB | ROUT | YE;
    exp_tab[4] = RUN | GC | ROUT | ZLE | ADD;
    exp_tab[5] = RUN | ZLO | GA | RIN;
    run_instr("add2", 32'h1800_0000, 1'b0, 1'b0, 6);
    @(negedge clock);
    check_eq("final_fetch0", {1'b0, obs}, {1'b0, RUN | PCO | MARE | INC});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
